// File: rtl/snn_pkg.sv
// Shared types and arithmetic helpers for the
// spiking crossbar array (synapses and column neurons).
package snn_pkg;

  localparam int WIDTH_DEF  = 32;
  localparam int THRESH_DEF = 32;
  localparam int SAT_W      = 64;

  typedef enum logic [1:0] {
    WAIT,
    INTEG,
    EMIT,
    DONE
  } neuron_state_e;

  // Operands arrive sign-extended to SAT_W; result clamps to a w-bit range.
  function automatic logic signed [SAT_W-1:0] sat_add(
    input logic signed [SAT_W-1:0] a,
    input logic signed [SAT_W-1:0] b,
    input int                      w
  );
    logic signed [SAT_W-1:0] s;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    s  = a + b;
    hi = (SAT_W'(1) << (w - 1)) - SAT_W'(1);
    lo = ~hi;
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/column_neuron_if.sv
// Spike record handshake from a column neuron
// to the spike collector.
interface column_neuron_if;

  logic        out_valid;
  logic        out_ready;
  logic        out_spike;
  logic [15:0] out_col;

  modport master (
    output out_valid,
    output out_spike,
    output out_col,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_spike,
    input  out_col,
    output out_ready
  );

endinterface

// File: rtl/spike_delay_line.sv
// Axonal delay line: bit i holds a spike due
// i+1 timesteps from now.
module spike_delay_line #(
  parameter  int MAX_DELAY = 8,
  localparam int DW        = $clog2(MAX_DELAY) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          advance,
  input  logic          fire,
  input  logic [DW-1:0] d,
  output logic          emit
);

  logic [MAX_DELAY-1:0] dline_q;
  logic [MAX_DELAY-1:0] dline_d;
  logic [MAX_DELAY-1:0] ins;

  always_comb begin
    ins = '0;
    if (fire && d != '0)
      ins = MAX_DELAY'(1) << (d - DW'(1));
    dline_d = dline_q;
    if (advance)
      dline_d = (dline_q >> 1) | ins;
    emit = dline_q[0] | (fire && d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dline_q <= '0;
    else        dline_q <= dline_d;
  end

endmodule

// File: rtl/column_neuron.sv
// Leaky integrate-and-fire neuron terminating one
// crossbar column; emits one spike record per timestep.
module column_neuron
  import snn_pkg::*;
#(
  parameter  int WIDTH      = WIDTH_DEF,
  parameter  int THRESH     = THRESH_DEF,
  parameter  int LEAK_SHIFT = 4,
  parameter  int REFRACT    = 2,
  parameter  int MAX_DELAY  = 8,
  parameter  int COL        = -1,
  localparam int DW         = $clog2(MAX_DELAY) + 1
) (
  input  logic                    clk,
  input  logic                    enable,
  input  logic signed [WIDTH-1:0] mac_in,
  input  logic                    spk_above,
  input  logic [DW-1:0]           delay,
  column_neuron_if.master         out_if,
  output logic signed [WIDTH-1:0] vmem,
  output logic                    done
);

  localparam int RW = $clog2(REFRACT + 2);
  localparam logic signed [WIDTH-1:0] TH    = WIDTH'(THRESH);
  localparam logic signed [WIDTH-1:0] FLOOR = -TH;

  neuron_state_e state_q, state_d;

  logic signed [WIDTH-1:0] v_q, v_d;
  logic signed [WIDTH-1:0] leak, v_sat, v_next;
  logic [RW-1:0]           refr_q, refr_d;
  logic                    spk_q;
  logic                    valid_q, valid_d;
  logic                    spike_q, spike_d;
  logic                    done_q, done_d;
  logic                    integ, fire, emit;
  logic [DW-1:0]           d_clamp;

  assign integ   = state_q == INTEG;
  assign d_clamp = (delay > DW'(MAX_DELAY)) ? DW'(MAX_DELAY) : delay;

  always_comb begin
    leak = '0;
    if (LEAK_SHIFT != 0)
      leak = v_q >>> LEAK_SHIFT;
    v_sat  = WIDTH'(sat_add(SAT_W'(v_q - leak),
                            SAT_W'(mac_in), WIDTH));
    v_next = (v_sat < FLOOR) ? FLOOR : v_sat;
    fire   = integ && (refr_q == '0) && (v_next >= TH);
  end

  spike_delay_line #(
    .MAX_DELAY (MAX_DELAY)
  ) u_dline (
    .clk     (clk),
    .rst_n   (enable),
    .advance (integ),
    .fire    (fire),
    .d       (d_clamp),
    .emit    (emit)
  );

  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    refr_d  = refr_q;
    valid_d = valid_q;
    spike_d = spike_q;
    done_d  = done_q;
    unique case (state_q)
      WAIT: begin
        if (spk_above && !spk_q)
          state_d = INTEG;
      end
      INTEG: begin
        if (refr_q != '0) begin
          refr_d = refr_q - RW'(1);
          v_d    = '0;
        end else if (fire) begin
          refr_d = RW'(REFRACT);
          v_d    = '0;
        end else begin
          v_d    = v_next;
        end
        spike_d = emit;
        valid_d = 1'b1;
        state_d = EMIT;
      end
      EMIT: begin
        if (out_if.out_ready) begin
          valid_d = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (!spk_above) begin
          done_d  = 1'b0;
          state_d = WAIT;
        end
      end
      default: state_d = WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge enable) begin
    if (!enable) begin
      state_q <= WAIT;
      v_q     <= '0;
      refr_q  <= '0;
      spk_q   <= 1'b0;
      valid_q <= 1'b0;
      spike_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      refr_q  <= refr_d;
      spk_q   <= spk_above;
      valid_q <= valid_d;
      spike_q <= spike_d;
      done_q  <= done_d;
    end
  end

  assign out_if.out_valid = valid_q;
  assign out_if.out_spike = spike_q;
  assign out_if.out_col   = 16'(COL);
  assign vmem             = v_q;
  assign done             = done_q;

endmodule

// File: tb/tb_column_neuron.sv
// Directed-vector bench for column_neuron with a
// queue scoreboard checked by an independent monitor.
module tb_column_neuron;

  localparam int W  = 32;
  localparam int DW = 4;

  typedef struct {
    logic              rst;
    logic signed [W-1:0] m;
    logic [DW-1:0]     d;
    logic              s;
    logic signed [W-1:0] v;
  } vec_t;

  logic                clk = 1'b0;
  logic                enable;
  logic signed [W-1:0] mac_in;
  logic                spk_above;
  logic [DW-1:0]       delay;
  logic signed [W-1:0] vmem;
  logic                done;

  int n_vec = 0;
  int n_bad = 0;
  logic [W:0] exp_q[$];
  vec_t vt[27];

  always #5 clk = ~clk;

  column_neuron_if bus();

  column_neuron #(
    .WIDTH      (32),
    .THRESH     (32),
    .LEAK_SHIFT (4),
    .REFRACT    (2),
    .MAX_DELAY  (8),
    .COL        (-1)
  ) dut (
    .clk       (clk),
    .enable    (enable),
    .mac_in    (mac_in),
    .spk_above (spk_above),
    .delay     (delay),
    .out_if    (bus.master),
    .vmem      (vmem),
    .done      (done)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  always @(negedge clk) begin
    logic [W:0] e;
    if (enable && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_record", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("out_spike", 32'(bus.out_spike), 32'(e[W]));
        check("vmem", vmem, e[W-1:0]);
      end
    end
  end

  task automatic wait_done(input logic lvl);
    for (int k = 0; k < 40; k++) begin
      if (done === lvl) break;
      @(posedge clk); #1;
    end
    check("done_wait", 32'(done), 32'(lvl));
  endtask

  task automatic do_reset();
    spk_above     = 1'b0;
    bus.out_ready = 1'b0;
    enable        = 1'b0;
    repeat (2) @(posedge clk);
    #1 enable = 1'b1;
  endtask

  task automatic run_ts(input vec_t t);
    if (t.rst) do_reset();
    @(posedge clk); #1;
    mac_in        = t.m;
    delay         = t.d;
    spk_above     = 1'b1;
    bus.out_ready = 1'b1;
    exp_q.push_back({t.s, t.v});
    wait_done(1'b1);
    spk_above = 1'b0;
    wait_done(1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt = '{
      '{1'b0, 32'sd20,  4'd0, 1'b0, 32'sd20},
      '{1'b0, 32'sd20,  4'd0, 1'b1, 32'sd0},
      '{1'b0, 32'sd100, 4'd0, 1'b0, 32'sd0},
      '{1'b0, 32'sd100, 4'd0, 1'b0, 32'sd0},
      '{1'b0, 32'sd100, 4'd0, 1'b1, 32'sd0},
      '{1'b1, 32'sd20,  4'd3, 1'b0, 32'sd20},
      '{1'b0, 32'sd20,  4'd3, 1'b0, 32'sd0},
      '{1'b0, 32'sd0,   4'd3, 1'b0, 32'sd0},
      '{1'b0, 32'sd0,   4'd3, 1'b0, 32'sd0},
      '{1'b0, 32'sd0,   4'd3, 1'b1, 32'sd0},
      '{1'b1, 32'sd20,  4'd9, 1'b0, 32'sd20},
      '{1'b0, 32'sd20,  4'd9, 1'b0, 32'sd0},
      '{1'b0, 32'sd0,   4'd9, 1'b0, 32'sd0},
      '{1'b0, 32'sd0,   4'd9, 1'b0, 32'sd0},
      '{1'b0, 32'sd0,   4'd9, 1'b0, 32'sd0},
      '{1'b0, 32'sd0,   4'd9, 1'b0, 32'sd0},
      '{1'b0, 32'sd0,   4'd9, 1'b0, 32'sd0},
      '{1'b0, 32'sd0,   4'd9, 1'b0, 32'sd0},
      '{1'b0, 32'sd0,   4'd9, 1'b0, 32'sd0},
      '{1'b0, 32'sd0,   4'd9, 1'b1, 32'sd0},
      '{1'b1, -32'sd100, 4'd0, 1'b0, -32'sd32},
      '{1'b0, 32'h80000000, 4'd0, 1'b0, -32'sd32},
      '{1'b0, 32'sd63,  4'd0, 1'b1, 32'sd0},
      '{1'b0, 32'sd0,   4'd0, 1'b0, 32'sd0},
      '{1'b0, 32'sd0,   4'd0, 1'b0, 32'sd0},
      '{1'b0, 32'sd31,  4'd0, 1'b0, 32'sd31},
      '{1'b0, 32'h7FFFFFF0, 4'd0, 1'b1, 32'sd0}
    };

    enable        = 1'b0;
    mac_in        = '0;
    delay         = '0;
    spk_above     = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_vmem", vmem, 32'd0);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_spike", 32'(bus.out_spike), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("out_col", 32'(bus.out_col), 32'h0000FFFF);
    enable = 1'b1;

    foreach (vt[i]) run_ts(vt[i]);

    // Back-pressure: record must hold while the collector stalls.
    do_reset();
    @(posedge clk); #1;
    mac_in    = 32'sd40;
    delay     = '0;
    spk_above = 1'b1;
    exp_q.push_back({1'b1, 32'sd0});
    @(posedge clk); #1;
    check("lat_cycle1_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_cycle2_valid", 32'(bus.out_valid), 32'd1);
    repeat (5) begin
      @(posedge clk); #1;
      check("stall_valid", 32'(bus.out_valid), 32'd1);
      check("stall_spike", 32'(bus.out_spike), 32'd1);
      check("stall_done", 32'(done), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("accept_done", 32'(done), 32'd1);
    check("accept_valid", 32'(bus.out_valid), 32'd0);
    repeat (3) begin
      @(posedge clk); #1;
      check("done_hold", 32'(done), 32'd1);
    end
    spk_above = 1'b0;
    @(posedge clk); #1;
    check("done_clear", 32'(done), 32'd0);

    // Reset lands mid-EMIT; the pending record is dropped.
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    mac_in    = 32'sd5;
    spk_above = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    enable    = 1'b0;
    spk_above = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_spike", 32'(bus.out_spike), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_vmem", vmem, 32'd0);
    @(posedge clk); #1;
    enable = 1'b1;
    run_ts('{1'b0, 32'sd40, 4'd0, 1'b1, 32'sd0});

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
